// File: rtl/interrupt_service_responder_if.sv
// Controller <-> responder request/grant/complete bundle.
// master = interrupt controller side, slave = service responder side.
interface interrupt_service_responder_if #(
  parameter int NINTR = 4,
  parameter int CW    = 8
);
  localparam int IDXW = (NINTR > 1) ? $clog2(NINTR) : 1;

  // irq/ack form a level request: ack is only meaningful while irq=1, and the
  // responder answers each accepted grant with a single-cycle done pulse; the
  // controller must drop irq for at least one sampled cycle before re-granting.
  logic             irq;
  logic [NINTR-1:0] ack;
  logic [CW-1:0]    svc_cycles;
  logic             done;
  logic             busy;
  logic [IDXW-1:0]  vec;

  modport master (
    output irq, ack, svc_cycles,
    input  done, busy, vec
  );

  modport slave (
    input  irq, ack, svc_cycles,
    output done, busy, vec
  );
endinterface

// File: rtl/interrupt_service_responder.sv
// CPU-side interrupt responder: latches a one-hot grant, emulates a service
// routine of programmable length, pulses done, and tracks preemption/errors.
module interrupt_service_responder #(
  parameter int NINTR   = 4,
  parameter int CW      = 8,
  parameter int CNTW    = 16,
  parameter int HOLD_TO = 15,
  localparam int IDXW   = (NINTR > 1) ? $clog2(NINTR) : 1,
  localparam int HW     = $clog2(HOLD_TO + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  interrupt_service_responder_if.slave  bus,
  input  logic                          err_clr,
  output logic                          dropped,
  output logic [IDXW-1:0]               dropped_vec,
  output logic                          aborted,
  output logic                          err_proto,
  output logic [CNTW-1:0]               serviced_cnt,
  output logic [1:0]                    state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    DONE    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [HW-1:0]    hcnt, hcnt_nx;
  logic [NINTR-1:0] ack_q, ack_nx;
  logic [IDXW-1:0]  vec_nx, dvec_nx;
  logic             drop_nx, abort_nx, err_set;

  logic             ack_onehot;
  logic [IDXW-1:0]  ack_idx;
  logic [CW-1:0]    svc_load;

  assign state_dbg = state;

  assign ack_onehot = (bus.ack != '0) && ((bus.ack & (bus.ack - NINTR'(1))) == '0);
  // A zero length is serviced as one cycle.
  assign svc_load   = (bus.svc_cycles == '0) ? '0 : bus.svc_cycles - CW'(1);

  always_comb begin
    ack_idx = '0;
    for (int i = 0; i < NINTR; i++) begin
      if (bus.ack[i]) ack_idx = IDXW'(i);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    ack_nx   = ack_q;
    vec_nx   = bus.vec;
    dvec_nx  = dropped_vec;
    drop_nx  = 1'b0;
    abort_nx = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.irq) begin
          if (ack_onehot) begin
            vec_nx   = ack_idx;
            ack_nx   = bus.ack;
            cnt_nx   = svc_load;
            state_nx = SERVICE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      SERVICE: begin
        if (!bus.irq) begin
          abort_nx = 1'b1;
          state_nx = IDLE;
        end else if (ack_onehot && (bus.ack != ack_q)) begin
          // Higher-priority grant: restart the routine for the new source.
          drop_nx = 1'b1;
          dvec_nx = bus.vec;
          vec_nx  = ack_idx;
          ack_nx  = bus.ack;
          cnt_nx  = svc_load;
        end else begin
          if (!ack_onehot) err_set = 1'b1;
          if (cnt == '0) state_nx = DONE;
          else           cnt_nx   = cnt - CW'(1);
        end
      end
      DONE: begin
        hcnt_nx  = '0;
        state_nx = HOLD;
      end
      HOLD: begin
        if (!bus.irq) begin
          state_nx = IDLE;
        end else if (hcnt == HW'(HOLD_TO - 1)) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      ack_q        <= '0;
      bus.vec      <= '0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      dropped      <= 1'b0;
      dropped_vec  <= '0;
      aborted      <= 1'b0;
      err_proto    <= 1'b0;
      serviced_cnt <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      hcnt        <= hcnt_nx;
      ack_q       <= ack_nx;
      bus.vec     <= vec_nx;
      bus.done    <= (state_nx == DONE);
      bus.busy    <= (state_nx != IDLE);
      dropped     <= drop_nx;
      dropped_vec <= dvec_nx;
      aborted     <= abort_nx;
      // A new error in the same cycle as err_clr keeps the flag set.
      err_proto   <= (err_proto & ~err_clr) | err_set;
      if ((state_nx == DONE) && (serviced_cnt != '1))
        serviced_cnt <= serviced_cnt + CNTW'(1);
    end
  end

endmodule
